// File: rtl/shift_add_mul_ctrl_pkg.sv
// Shared definitions for the shift-and-add multiplier controller:
// operand/product widths, iteration count and FSM state encoding.
package shift_add_mul_ctrl_pkg;

  localparam int MUL_W  = 8;
  localparam int PROD_W = 16;
  localparam int STEPS  = 8;

  // Value of the step counter on the final iteration.
  localparam logic [2:0] LAST_STEP = 3'd7;

  // Encoding 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_mul_ctrl_if.sv
// Operand and result handshake bundle for the shift-and-add multiplier.
//   start_valid/start_ready/a/b : operand pair transfer into the multiplier
//   res_valid/res_ready/product : product transfer out of the multiplier
//   busy                        : multiplier is working on or holding a result
// master = operand source / result consumer, slave = multiplier.
interface shift_add_mul_ctrl_if;
  import shift_add_mul_ctrl_pkg::*;

  logic              start_valid;
  logic              start_ready;
  logic [MUL_W-1:0]  a;
  logic [MUL_W-1:0]  b;
  logic              res_valid;
  logic              res_ready;
  logic [PROD_W-1:0] product;
  logic              busy;

  modport master (
    output start_valid, a, b, res_ready,
    input  start_ready, res_valid, product, busy
  );

  modport slave (
    input  start_valid, a, b, res_ready,
    output start_ready, res_valid, product, busy
  );

endinterface

// File: rtl/ADDER_8bit.sv
// 8-bit ripple-carry adder built from a chain of full adders.
//   x, y : addends
//   cin  : carry in
//   sum  : low 8 bits of x + y + cin
//   cout : carry out of bit 7
module ADDER_8bit (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] carry_s;

  assign carry_s[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign sum[i]       = x[i] ^ y[i] ^ carry_s[i];
    assign carry_s[i+1] = (x[i] & y[i]) | (carry_s[i] & (x[i] ^ y[i]));
  end

  assign cout = carry_s[8];

endmodule

// File: rtl/SWITCH_8bit.sv
// 8-bit AND gate: passes din when en is high, otherwise drives zero.
//   din  : data in
//   en   : gate enable, applied to every bit
//   dout : gated data out
module SWITCH_8bit (
  input  logic [7:0] din,
  input  logic       en,
  output logic [7:0] dout
);

  assign dout = din & {8{en}};

endmodule

// File: rtl/shift_add_mul_dp.sv
// Shift-and-add datapath: holds the multiplicand and the combined
// accumulator/multiplier register, and performs one iteration per step.
//   clk, rst_n : clock, async active-low reset
//   load       : capture a into mcand and {0, b} into acc
//   step       : replace acc with acc_next
//   a, b       : operands
//   acc_next   : acc after the current iteration (used for the final product)
module shift_add_mul_dp
  import shift_add_mul_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [MUL_W-1:0]  a,
  input  logic [MUL_W-1:0]  b,
  output logic [PROD_W-1:0] acc_next
);

  logic [MUL_W-1:0]  mcand_r;
  logic [PROD_W-1:0] acc_r;
  logic [MUL_W-1:0]  gated_s;
  logic [MUL_W-1:0]  sum_s;
  logic              carry_s;

  // Multiplicand is added only when the current multiplier LSB is set.
  SWITCH_8bit u_switch (
    .din  (mcand_r),
    .en   (acc_r[0]),
    .dout (gated_s)
  );

  ADDER_8bit u_adder (
    .x    (acc_r[15:8]),
    .y    (gated_s),
    .cin  (1'b0),
    .sum  (sum_s),
    .cout (carry_s)
  );

  // Carry becomes the new MSB so no bit of the partial product is lost;
  // the consumed multiplier bit drops off the bottom.
  assign acc_next = {carry_s, sum_s, acc_r[7:1]};

  // Operand capture and per-step accumulator update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r <= 8'h00;
      acc_r   <= 16'h0000;
    end else if (load) begin
      mcand_r <= a;
      acc_r   <= {8'h00, b};
    end else if (step) begin
      acc_r   <= acc_next;
    end
  end

endmodule

// File: rtl/shift_add_mul_ctrl.sv
// Sequential 8x8 -> 16 unsigned multiplier controller. Accepts an operand
// pair in IDLE, iterates one multiplier bit per cycle for 8 cycles in RUN,
// then presents the product in DONE until the consumer accepts it.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of the operand/result handshake bundle
module shift_add_mul_ctrl
  import shift_add_mul_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  shift_add_mul_ctrl_if.slave  bus
);

  state_t            state_r;
  state_t            next_s;
  logic [2:0]        cnt_r;
  logic [PROD_W-1:0] prod_r;
  logic              res_valid_r;
  logic              busy_r;
  logic              load_s;
  logic              step_s;
  logic              last_s;
  logic [PROD_W-1:0] acc_next_s;

  shift_add_mul_dp u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_s),
    .step     (step_s),
    .a        (bus.a),
    .b        (bus.b),
    .acc_next (acc_next_s)
  );

  assign last_s = (cnt_r == LAST_STEP);

  // Next-state and datapath strobe decode.
  always_comb begin
    next_s = state_r;
    load_s = 1'b0;
    step_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start_valid) begin
          load_s = 1'b1;
          next_s = ST_RUN;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        step_s = 1'b1;
        if (last_s) begin
          next_s = ST_DONE;
        end else begin
          next_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.res_ready) begin
          next_s = ST_IDLE;
        end else begin
          next_s = ST_DONE;
        end
      end
      default: begin
        next_s = ST_IDLE;
      end
    endcase
  end

  // State, step counter, registered status flags and product hold register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 3'd0;
      prod_r      <= 16'h0000;
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= next_s;
      res_valid_r <= (next_s == ST_DONE);
      busy_r      <= (next_s == ST_RUN) || (next_s == ST_DONE);
      if (load_s) begin
        cnt_r <= 3'd0;
      end else if (step_s) begin
        cnt_r <= cnt_r + 3'd1;
      end
      // Product only changes on the RUN->DONE edge, held everywhere else.
      if (step_s && last_s) begin
        prod_r <= acc_next_s;
      end
    end
  end

  assign bus.start_ready = (state_r == ST_IDLE);
  assign bus.res_valid   = res_valid_r;
  assign bus.busy        = busy_r;
  assign bus.product     = prod_r;

endmodule
